// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control encodings and widths
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    // Hazard FSM state encodings; code 3 is never entered deliberately
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    // ALU control codes seen in ID/EX; a bubble loads ALU_NOP
    localparam logic [1:0] ALU_NOP = 2'b00;
    localparam logic [1:0] ALU_JC  = 2'b10;
    localparam logic [1:0] ALU_JZ  = 2'b11;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side hazard signals and control outputs
interface hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = pipe_ctrl_pkg::REG_W
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch;
    logic             ex_taken;
    logic             mem_busy;
    logic             cnt_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic [1:0]       state;
    logic [15:0]      stall_cnt;

    // Pipeline datapath side: supplies stage status, consumes controls
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch, ex_taken, mem_busy, cnt_clr,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               state, stall_cnt
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch, ex_taken, mem_busy, cnt_clr,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               state, stall_cnt
    );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational LW-to-use register hazard compare
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    output logic             o_hazard
);
    logic w_rs_hit;
    logic w_rt_hit;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency
    assign w_rs_hit = (i_ex_rd == i_id_rs);
    assign w_rt_hit = i_id_uses_rt & (i_ex_rd == i_id_rt);
    assign o_hazard = i_id_valid & i_ex_mem_read & (i_ex_rd != '0) & (w_rs_hit | w_rt_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze controller FSM
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_W        = pipe_ctrl_pkg::REG_W
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);
    logic [1:0]  r_state;
    logic [1:0]  r_flush_cnt;
    logic [15:0] r_stall_cnt;

    logic        w_load_use;
    logic        w_taken;
    logic [1:0]  w_next_state;
    logic [1:0]  w_next_flush_cnt;
    logic        w_pc_write;
    logic        w_ifid_write;
    logic        w_ifid_flush;
    logic        w_idex_bubble;
    logic        w_pipe_freeze;

    load_use_detect #(.REG_W(REG_W)) u_load_use (
        .i_id_valid    (bus.id_valid),
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_id_uses_rt  (bus.id_uses_rt),
        .i_ex_mem_read (bus.ex_mem_read),
        .i_ex_rd       (bus.ex_rd),
        .o_hazard      (w_load_use)
    );

    assign w_taken = bus.ex_branch & bus.ex_taken;

    // Control outputs and next state: reset, then mem_busy, then jump, then load-use
    always_comb begin
        w_pc_write       = 1'b1;
        w_ifid_write     = 1'b1;
        w_ifid_flush     = 1'b0;
        w_idex_bubble    = 1'b0;
        w_pipe_freeze    = 1'b0;
        w_next_state     = r_state;
        w_next_flush_cnt = r_flush_cnt;
        if (!rst_n) begin
            w_pc_write       = 1'b0;
            w_ifid_write     = 1'b0;
            w_ifid_flush     = 1'b1;
            w_idex_bubble    = 1'b1;
            w_next_state     = ST_RUN;
            w_next_flush_cnt = 2'd0;
        end else if (bus.mem_busy) begin
            // Whole pipeline holds; a pending flush resumes once memory is ready
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_pipe_freeze = 1'b1;
            case (r_state)
                ST_FLUSH:            w_next_state = ST_FLUSH;
                ST_RUN, ST_MEM_WAIT: w_next_state = ST_MEM_WAIT;
                default:             w_next_state = ST_RUN;
            endcase
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    // EX holds a bubble here, so neither jumps nor load-use apply
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                    if (r_flush_cnt <= 2'd1) begin
                        w_next_state     = ST_RUN;
                        w_next_flush_cnt = 2'd0;
                    end else begin
                        w_next_flush_cnt = r_flush_cnt - 2'd1;
                    end
                end
                ST_RUN, ST_MEM_WAIT: begin
                    w_next_state = ST_RUN;
                    if (w_taken) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_next_state     = ST_FLUSH;
                            w_next_flush_cnt = 2'(FLUSH_CYCLES - 1);
                        end
                    end else if (w_load_use) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                    end
                end
                default: begin
                    w_next_state     = ST_RUN;
                    w_next_flush_cnt = 2'd0;
                end
            endcase
        end
    end

    // FSM state and remaining-flush counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_flush_cnt;
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (bus.cnt_clr) begin
            r_stall_cnt <= 16'd0;
        end else if (!w_pc_write && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.pipe_freeze = w_pipe_freeze;
    assign bus.state       = r_state;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int FC = 2;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    hazard_ctrl_if #(.REG_W(5)) bus ();

    hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: flush cycles delivered for the pending jump, and whether memory held us
    int m_done;
    bit m_wait;
    int m_stalls;

    task automatic model_reset();
        m_done   = 0;
        m_wait   = 1'b0;
        m_stalls = 0;
    endtask

    // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, state, stall_cnt}
    function automatic logic [22:0] model_expect();
        logic [4:0] ctl;
        logic [1:0] st;
        bit lu;
        bit tj;
        bit flushing;
        flushing = (m_done > 0);
        st = flushing ? 2'd1 : (m_wait ? 2'd2 : 2'd0);
        lu = bus.id_valid && bus.ex_mem_read && (bus.ex_rd != 0) &&
             ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
        tj = bus.ex_branch && bus.ex_taken;
        if (!rst_n)            ctl = 5'b00110;
        else if (bus.mem_busy) ctl = 5'b00001;
        else if (flushing)     ctl = 5'b11110;
        else if (tj)           ctl = 5'b11110;
        else if (lu)           ctl = 5'b00010;
        else                   ctl = 5'b11000;
        return {ctl, st, 16'(m_stalls)};
    endfunction

    task automatic model_advance(input logic [22:0] e);
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (bus.cnt_clr) m_stalls = 0;
        else if (!e[22] && m_stalls < 65535) m_stalls++;
        if (bus.mem_busy) begin
            if (m_done == 0) m_wait = 1'b1;
        end else if (m_done > 0) begin
            m_done++;
            if (m_done == FC) m_done = 0;
        end else begin
            m_wait = 1'b0;
            if (bus.ex_branch && bus.ex_taken) m_done = (FC > 1) ? 1 : 0;
        end
    endtask

    function automatic logic [22:0] observe();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble,
                bus.pipe_freeze, bus.state, bus.stall_cnt};
    endfunction

    task automatic tick(input logic [22:0] e);
        model_advance(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit ur, input bit mr,
                         input int rd, input bit br, input bit tk, input bit busy, input bit clr);
        bus.id_valid    = v;
        bus.id_rs       = 5'(rs);
        bus.id_rt       = 5'(rt);
        bus.id_uses_rt  = ur;
        bus.ex_mem_read = mr;
        bus.ex_rd       = 5'(rd);
        bus.ex_branch   = br;
        bus.ex_taken    = tk;
        bus.mem_busy    = busy;
        bus.cnt_clr     = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [22:0] e;
        idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        n_vec++;
        if (observe() !== {5'b00110, 2'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", observe(), {5'b00110, 2'd0, 16'd0});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        e = model_expect();
        n_vec++;
        if (observe() !== {5'b11000, 2'd0, 16'd0} || e !== observe()) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", observe(), {5'b11000, 2'd0, 16'd0});
        end
        tick(e);
    endtask

    task automatic test_load_use();
        logic [22:0] e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            else if (i == 1) drive(1, 3, 7, 0, 1, 3, 0, 0, 0, 0);
            else             idle();
            @(negedge clk);
            e = model_expect();
            n_vec++;
            if (observe() !== e) begin
                n_err++;
                $display("FAIL load_use c%0d: got %h want %h", i, observe(), e);
            end
            if (i == 1) begin
                n_vec++;
                if (observe() !== {5'b00010, 2'd0, 16'd0}) begin
                    n_err++;
                    $display("FAIL load_use_stall: got %h want %h", observe(), {5'b00010, 2'd0, 16'd0});
                end
            end
            if (i == 2) begin
                n_vec++;
                if (bus.stall_cnt !== 16'd1) begin
                    n_err++;
                    $display("FAIL load_use_cnt: got %0d want 1", bus.stall_cnt);
                end
            end
            tick(e);
        end
    endtask

    task automatic test_zero_reg();
        logic [22:0] e;
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        e = model_expect();
        n_vec++;
        if (observe() !== e || bus.pc_write !== 1'b1 || bus.idex_bubble !== 1'b0) begin
            n_err++;
            $display("FAIL zero_reg: got %h want %h", observe(), e);
        end
        tick(e);
    endtask

    task automatic run_table(input string name, input int len, input bit busy_t[6], input bit jump_t[6],
                             input logic [1:0] st_t[6], input bit fl_t[6]);
        logic [22:0] e;
        for (int i = 0; i < len; i++) begin
            drive(0, 0, 0, 0, 0, 0, jump_t[i], jump_t[i], busy_t[i], 0);
            @(negedge clk);
            e = model_expect();
            n_vec++;
            if (observe() !== e || bus.state !== st_t[i] || bus.ifid_flush !== fl_t[i]) begin
                n_err++;
                $display("FAIL %s c%0d: got %h st=%0d fl=%0d want %h st=%0d fl=%0d",
                         name, i, observe(), bus.state, bus.ifid_flush, e, st_t[i], fl_t[i]);
            end
            tick(e);
        end
    endtask

    task automatic clear_cnt();
        logic [22:0] e;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        e = model_expect();
        tick(e);
    endtask

    task automatic test_jump_flush();
        clear_cnt();
        run_table("jump_flush", 3, '{0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0},
                  '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, '{1, 1, 0, 0, 0, 0});
    endtask

    task automatic test_busy_with_jump();
        clear_cnt();
        run_table("busy_jump", 6, '{1, 1, 1, 0, 0, 0}, '{1, 1, 1, 1, 0, 0},
                  '{2'd0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0}, '{0, 0, 0, 1, 1, 0});
        n_vec++;
        if (bus.stall_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL busy_jump_cnt: got %0d want 3", bus.stall_cnt);
        end
    endtask

    task automatic test_busy_in_flush();
        run_table("busy_flush", 5, '{0, 1, 1, 0, 0, 0}, '{1, 0, 0, 0, 0, 0},
                  '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0}, '{1, 0, 0, 1, 0, 0});
    endtask

    task automatic test_reset_mid_flush();
        logic [22:0] e;
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        e = model_expect();
        tick(e);
        idle();
        #2;
        n_vec++;
        if (bus.state !== 2'd1) begin
            n_err++;
            $display("FAIL rst_flush_pre: got state %0d want 1", bus.state);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (observe() !== {5'b00110, 2'd0, 16'd0}) begin
            n_err++;
            $display("FAIL rst_flush_async: got %h want %h", observe(), {5'b00110, 2'd0, 16'd0});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = model_expect();
            n_vec++;
            if (observe() !== {5'b11000, 2'd0, 16'd0} || e !== observe()) begin
                n_err++;
                $display("FAIL rst_flush_after c%0d: got %h want %h", i, observe(), {5'b11000, 2'd0, 16'd0});
            end
            tick(e);
        end
    endtask

    task automatic test_random();
        logic [22:0] e;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
            @(negedge clk);
            e = model_expect();
            n_vec++;
            if (observe() !== e) begin
                n_err++;
                $display("FAIL random c%0d: got %h want %h", i, observe(), e);
            end
            tick(e);
        end
    endtask

    task automatic test_saturation();
        logic [22:0] e;
        clear_cnt();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            e = model_expect();
            tick(e);
        end
        @(negedge clk);
        e = model_expect();
        n_vec++;
        if (observe() !== e || bus.stall_cnt !== 16'hFFFF || bus.state !== 2'd2) begin
            n_err++;
            $display("FAIL saturate: got %h want %h (cnt ffff state 2)", observe(), e);
        end
        tick(e);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        e = model_expect();
        n_vec++;
        if (observe() !== e || bus.stall_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL saturate_hold: got %h want %h", observe(), e);
        end
        tick(e);
        idle();
        @(negedge clk);
        e = model_expect();
        n_vec++;
        if (observe() !== e || bus.stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL cnt_clr: got %h want %h", observe(), e);
        end
        tick(e);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_jump_flush();
        test_busy_with_jump();
        test_busy_in_flush();
        test_reset_mid_flush();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, range 1..3; total cycles ifid_flush is asserted per taken jump.
REQ-002 Parameter REG_W, default 5; register-index width.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs  in  REG_W  ID source register 1.
REQ-007 id_rt  in  REG_W  ID source register 2.
REQ-008 id_uses_rt  in  1  ID instruction reads id_rt.
REQ-009 ex_mem_read  in  1  EX instruction is LW.
REQ-010 ex_rd  in  REG_W  EX destination register.
REQ-011 ex_branch  in  1  EX instruction is JC or JZ (ALU control code 10 or 11).
REQ-012 ex_taken  in  1  EX jump condition true; qualified by ex_branch.
REQ-013 mem_busy  in  1  data memory not ready; whole pipeline must hold.
REQ-014 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-015 pc_write  out  1  PC update enable.
REQ-016 ifid_write  out  1  IF/ID register load enable.
REQ-017 ifid_flush  out  1  IF/ID contents replaced by NOP.
REQ-018 idex_bubble  out  1  ID/EX loads NOP (ALU control 0) instead of ID output.
REQ-019 pipe_freeze  out  1  EX/MEM and MEM/WB registers hold.
REQ-020 state  out  2  current FSM state.
REQ-021 stall_cnt  out  16  saturating count of cycles with pc_write=0.

Function
REQ-022 The FSM has exactly three states: RUN=0, FLUSH=1, MEM_WAIT=2; code 3 is illegal and returns to RUN on the next edge.
REQ-023 Outputs are combinational from state and current inputs; only state, the flush counter and stall_cnt are registered.
REQ-024 Defaults, unless overridden below: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0.
REQ-025 Load-use hazard = id_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
REQ-026 Priority in every state: mem_busy > taken jump (ex_branch & ex_taken) > load-use hazard.
REQ-027 Any state with mem_busy=1: pc_write=0, ifid_write=0, pipe_freeze=1, idex_bubble=0, ifid_flush=0; the flush counter holds.
REQ-028 RUN with mem_busy=1: next state MEM_WAIT.
REQ-029 RUN with a taken jump: ifid_flush=1 and idex_bubble=1 in the same cycle; pc_write stays 1 for the redirect.
REQ-030 After a taken jump in RUN, next state is FLUSH if FLUSH_CYCLES>1 (counter loaded with FLUSH_CYCLES-1); otherwise RUN.
REQ-031 RUN with a load-use hazard only: pc_write=0, ifid_write=0, idex_bubble=1 for that single cycle; state remains RUN.
REQ-032 FLUSH: ifid_flush=1 and idex_bubble=1; load-use is ignored; the counter decrements each non-busy cycle; at count 1 the next state is RUN.
REQ-033 MEM_WAIT: stays while mem_busy=1 and returns to RUN on the first cycle mem_busy=0, with RUN rules applied in that cycle.
REQ-034 FLUSH with mem_busy=1: the state remains FLUSH and the freeze rules of REQ-027 apply.
REQ-035 stall_cnt increments when pc_write=0 and saturates at 16'hFFFF.
REQ-036 cnt_clr has priority over increment and loads 0.

Reset
REQ-037 rst_n=0 immediately forces state=RUN, flush counter=0 and stall_cnt=0.
REQ-038 While rst_n=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0.
REQ-039 Reset asserted mid-FLUSH or mid-MEM_WAIT abandons the operation, with no residual flush after release.

Structure
REQ-040 Shared package pipe_ctrl_pkg holds the state encodings, REG_W, and ALU control codes (NOP=0, JC=10, JZ=11).
REQ-041 Hazard comparison lives in a combinational sub-module load_use_detect; the FSM, counters and output logic stay in hazard_ctrl.

Verification
REQ-042 ex_mem_read=1, ex_rd=3, id_rs=3, id_valid=1 -> one cycle of pc_write=0, idex_bubble=1; stall_cnt=1.
REQ-043 ex_rd=0 with id_rs=0 and ex_mem_read=1 -> no stall.
REQ-044 Taken JZ in RUN (FLUSH_CYCLES=2) -> ifid_flush=1 for 2 cycles, state sequence RUN,FLUSH,RUN.
REQ-045 mem_busy=1 for 3 cycles together with a taken jump -> freeze for 3 cycles with no flush, then the flush sequence runs; stall_cnt=3 after freeze.
REQ-046 mem_busy pulsed during FLUSH -> flush extends by the busy cycles.
REQ-047 rst_n low mid-FLUSH -> state=0 asynchronously; stall_cnt saturates at 65535 under a held mem_busy; cnt_clr zeroes it.
